// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type constants, CRC parameters and the
// header ECC / payload CRC helper functions used by both TX and RX paths.
package csi2_pkg;

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LINE_START  = 6'h02;
    localparam logic [5:0] DT_LINE_END    = 6'h03;
    localparam logic [5:0] DT_RAW8        = 6'h2A;
    localparam logic [5:0] DT_RAW10       = 6'h2B;
    localparam logic [5:0] DT_LONG_MIN    = 6'h10;

    localparam logic [15:0] CRC16_POLY = 16'h8408;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_FOOTER
    } tx_state_t;

    function automatic logic is_short_dt(input logic [5:0] dt);
        return dt < DT_LONG_MIN;
    endfunction

    // Hamming parity over {WC[15:8], WC[7:0], DI}; each mask selects the data bits feeding one parity bit.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_crc16_2b.sv
// Combinational CSI-2 CRC-16 next state for one byte pair, low byte first.
module csi2_crc16_2b
    import csi2_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc16_byte(crc16_byte(crc_in, data[7:0]), data[15:8]);
    end

endmodule

// File: rtl/csi2_packet_tx.sv
// CSI-2 transmit packetizer for the 16-bit byte-pair datapath: header with
// ECC, payload pass-through with CRC accumulation, and CRC footer.
module csi2_packet_tx
    import csi2_pkg::*;
#(
    parameter logic ODD_WC_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  vc,
    input  logic [5:0]  data_type,
    input  logic [15:0] word_count,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        busy,
    output logic        err
);

    tx_state_t   state_q, state_d;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic [5:0]  ecc_q;
    logic        short_q;
    logic        odd_q;
    logic [16:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d, crc_pay;
    logic [15:0] pay_word, word_d;
    logic        out_free, load, sop_d, eop_d, capture, err_d;

    // Busy covers the window where the final word is still held in the output register.
    assign busy     = (state_q != ST_IDLE) || out_valid;
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state_q == ST_PAYLOAD) && out_free;

    always_comb begin
        pay_word = in_data;
        if (odd_q && rem_q == 17'd2) begin
            pay_word[15:8] = 8'h00;
        end
    end

    csi2_crc16_2b u_crc (
        .crc_in  (crc_q),
        .data    (pay_word),
        .crc_out (crc_pay)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        word_d  = out_data;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        crc_d   = crc_q;
        rem_d   = rem_q;
        capture = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                crc_d = CRC16_SEED;
                if (start && !busy) begin
                    if (ODD_WC_ERR && !is_short_dt(data_type) && word_count[0]) begin
                        err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                if (out_free) begin
                    load    = 1'b1;
                    word_d  = {wc_q[7:0], di_q};
                    sop_d   = 1'b1;
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (out_free) begin
                    load   = 1'b1;
                    word_d = {2'b00, ecc_q, wc_q[15:8]};
                    if (short_q) begin
                        eop_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rem_q == '0) begin
                        state_d = ST_FOOTER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid && in_ready) begin
                    load   = 1'b1;
                    word_d = pay_word;
                    crc_d  = crc_pay;
                    rem_d  = rem_q - 17'd2;
                    if (rem_q <= 17'd2) begin
                        state_d = ST_FOOTER;
                    end
                end
            end
            ST_FOOTER: begin
                if (out_free) begin
                    load    = 1'b1;
                    word_d  = crc_q;
                    eop_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q     <= CRC16_SEED;
            rem_q     <= '0;
            di_q      <= '0;
            wc_q      <= '0;
            ecc_q     <= '0;
            short_q   <= 1'b0;
            odd_q     <= 1'b0;
            err       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err   <= err_d;
            if (capture) begin
                di_q    <= {vc, data_type};
                wc_q    <= word_count;
                ecc_q   <= csi2_ecc({word_count, vc, data_type});
                short_q <= is_short_dt(data_type);
                odd_q   <= word_count[0] && !is_short_dt(data_type);
                // Odd counts round up to whole byte pairs; the pad byte is zeroed on the last word.
                rem_q   <= {1'b0, word_count} + {16'h0000, word_count[0]};
            end else begin
                rem_q <= rem_d;
            end
            if (load) begin
                out_data  <= word_d;
                out_valid <= 1'b1;
                out_sop   <= sop_d;
                out_eop   <= eop_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Self-checking bench for csi2_packet_tx: directed and randomized packets
// compared against a byte-level packet model built from the CSI-2 rules.
module tb_csi2_packet_tx;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready, sel;
    logic [1:0]  vc;
    logic [5:0]  data_type;
    logic [15:0] word_count, in_data;

    logic        a_in_ready, a_out_valid, a_out_sop, a_out_eop, a_busy, a_err;
    logic [15:0] a_out_data;
    logic        p_in_ready, p_out_valid, p_out_sop, p_out_eop, p_busy, p_err;
    logic [15:0] p_out_data;
    logic        start_a, start_b;

    logic        o_in_ready, o_valid, o_sop, o_eop, o_busy, o_err;
    logic [15:0] o_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] pl_q[$];
    logic [15:0] exp_w[$];
    logic [15:0] got_w[$];
    logic        got_sop[$];
    logic        got_eop[$];

    // Syndrome column of each header data bit D0..D23.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    localparam logic [15:0] CRC_VEC [12] = '{
        16'h00FF, 16'h0000, 16'hF01E, 16'hC71E, 16'h824F, 16'hC578,
        16'hE082, 16'h708C, 16'h3CD2, 16'hE978, 16'h00FF, 16'h0100
    };

    assign start_a    = start && !sel;
    assign start_b    = start && sel;
    assign o_in_ready = sel ? p_in_ready  : a_in_ready;
    assign o_valid    = sel ? p_out_valid : a_out_valid;
    assign o_sop      = sel ? p_out_sop   : a_out_sop;
    assign o_eop      = sel ? p_out_eop   : a_out_eop;
    assign o_busy     = sel ? p_busy      : a_busy;
    assign o_err      = sel ? p_err       : a_err;
    assign o_data     = sel ? p_out_data  : a_out_data;

    csi2_packet_tx dut (
        .clk(clk), .rst(rst), .start(start_a), .vc(vc), .data_type(data_type),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sop(a_out_sop), .out_eop(a_out_eop),
        .busy(a_busy), .err(a_err)
    );

    csi2_packet_tx #(.ODD_WC_ERR(1'b0)) dut_pad (
        .clk(clk), .rst(rst), .start(start_b), .vc(vc), .data_type(data_type),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(p_in_ready), .out_data(p_out_data), .out_valid(p_out_valid),
        .out_ready(out_ready), .out_sop(p_out_sop), .out_eop(p_out_eop),
        .busy(p_busy), .err(p_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] e = '0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e ^= ECC_COL[i];
        end
        return e;
    endfunction

    // Expected packet words: header, payload (pad byte zeroed), bit-serial CRC footer.
    task automatic build_expected(input logic [1:0] v, input logic [5:0] dt, input logic [15:0] wc);
        logic [7:0]  di;
        logic [15:0] crc, w;
        logic        fb;
        int          nw;
        di = {v, dt};
        exp_w.delete();
        exp_w.push_back({wc[7:0], di});
        exp_w.push_back({2'b00, ref_ecc({wc, di}), wc[15:8]});
        if (dt >= 6'h10) begin
            nw  = (int'(wc) + 1) / 2;
            crc = 16'hFFFF;
            for (int k = 0; k < nw; k++) begin
                w = pl_q[k];
                if (wc[0] && k == nw - 1) w[15:8] = 8'h00;
                exp_w.push_back(w);
                for (int b = 0; b < 16; b++) begin
                    fb  = crc[0] ^ w[b];
                    crc = crc >> 1;
                    if (fb) crc ^= 16'h8408;
                end
            end
            exp_w.push_back(crc);
        end
    endtask

    task automatic run_packet(input logic s, input logic [1:0] v, input logic [5:0] dt,
                              input logic [15:0] wc, input bit stall, input string tag);
        int          idx, cyc, eop_cyc, nw;
        bit          done, held;
        logic [15:0] held_d;
        logic        held_s, held_e;
        build_expected(v, dt, wc);
        nw = (dt >= 6'h10) ? (int'(wc) + 1) / 2 : 0;
        got_w.delete(); got_sop.delete(); got_eop.delete();
        sel = s;
        @(posedge clk); #1;
        start = 1'b1; vc = v; data_type = dt; word_count = wc;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_after_start"}, 32'(o_busy), 32'd1);
        idx = 0; cyc = 0; eop_cyc = -1; done = 0; held = 0;
        held_d = '0; held_s = 0; held_e = 0;
        while (!done && cyc < 3000) begin
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid  = (idx < nw) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = (idx < nw) ? pl_q[idx] : 16'($urandom);
            @(negedge clk);
            if (held) begin
                check({tag, ":stall_valid"}, 32'(o_valid), 32'd1);
                check({tag, ":stall_data"}, 32'(o_data), 32'(held_d));
                check({tag, ":stall_flags"}, 32'({o_sop, o_eop}), 32'({held_s, held_e}));
            end
            held   = o_valid && !out_ready;
            held_d = o_data; held_s = o_sop; held_e = o_eop;
            if (in_valid && o_in_ready) idx++;
            if (o_valid && out_ready) begin
                got_w.push_back(o_data);
                got_sop.push_back(o_sop);
                got_eop.push_back(o_eop);
                if (o_eop) begin
                    done = 1;
                    eop_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, ":completed"}, 32'(done), 32'd1);
        check({tag, ":busy_after_eop"}, 32'(o_busy), 32'd0);
        check({tag, ":word_count"}, 32'(got_w.size()), 32'(exp_w.size()));
        check({tag, ":payload_taken"}, 32'(idx), 32'(nw));
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            check($sformatf("%s:word%0d", tag, i), 32'(got_w[i]), 32'(exp_w[i]));
            check($sformatf("%s:sop%0d", tag, i), 32'(got_sop[i]), 32'(i == 0));
            check($sformatf("%s:eop%0d", tag, i), 32'(got_eop[i]), 32'(i == exp_w.size() - 1));
        end
        if (!stall) check({tag, ":eop_cycle"}, 32'(eop_cyc), 32'(exp_w.size()));
    endtask

    task automatic load_crc_vec();
        pl_q.delete();
        for (int i = 0; i < 12; i++) pl_q.push_back(CRC_VEC[i]);
    endtask

    task automatic load_random(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(16'($urandom));
    endtask

    initial begin
        logic [15:0] wc;
        logic [5:0]  dt;
        int          k;
        bit          seen_valid;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
        vc = '0; data_type = '0; word_count = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'({a_out_valid, p_out_valid}), 32'd0);
        check("reset_busy", 32'({a_busy, p_busy}), 32'd0);
        check("reset_err", 32'({a_err, p_err}), 32'd0);
        check("reset_in_ready", 32'({a_in_ready, p_in_ready}), 32'd0);
        check("reset_flags", 32'({a_out_sop, a_out_eop, p_out_sop, p_out_eop}), 32'd0);
        check("reset_data", 32'({a_out_data, p_out_data}), 32'd0);
        rst = 1'b0;

        load_crc_vec();
        run_packet(1'b0, 2'd0, 6'h2A, 16'd24, 1'b0, "crc_vec");
        check("crc_vec_footer", 32'(got_w[got_w.size() - 1]), 32'hE569);

        pl_q.delete();
        run_packet(1'b0, 2'd0, 6'h00, 16'd0, 1'b0, "short_zero");
        run_packet(1'b0, 2'd0, 6'h01, 16'd0, 1'b0, "short_di01");
        check("di01_hdr1", 32'(got_w[1]), 32'h0700);
        run_packet(1'b0, 2'd0, 6'h2A, 16'd0, 1'b0, "empty_long");
        check("empty_long_footer", 32'(got_w[got_w.size() - 1]), 32'hFFFF);

        load_crc_vec();
        run_packet(1'b0, 2'd0, 6'h2A, 16'd24, 1'b1, "crc_vec_bp");
        check("crc_vec_bp_footer", 32'(got_w[got_w.size() - 1]), 32'hE569);

        // Odd word count rejected by the default instance.
        sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; vc = 2'd1; data_type = 6'h2A; word_count = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("odd_err_pulse", 32'(o_err), 32'd1);
        check("odd_busy", 32'(o_busy), 32'd0);
        seen_valid = 0;
        repeat (5) begin
            @(posedge clk); #1;
            seen_valid |= o_valid;
        end
        check("odd_err_clear", 32'(o_err), 32'd0);
        check("odd_no_output", 32'(seen_valid), 32'd0);

        load_random(2);
        run_packet(1'b1, 2'd2, 6'h2B, 16'd3, 1'b0, "odd_pad");
        wc = 16'(2 * $urandom_range(0, 15) + 1);
        load_random((int'(wc) + 1) / 2);
        run_packet(1'b1, 2'd3, 6'h12, wc, 1'b1, "odd_pad_bp");

        // Reset in the middle of the payload.
        sel = 1'b0;
        load_crc_vec();
        @(posedge clk); #1;
        start = 1'b1; vc = 2'd0; data_type = 6'h2A; word_count = 16'd24;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 50 && k < 4; c++) begin
            in_valid = 1'b1;
            in_data  = pl_q[k];
            @(negedge clk);
            if (o_in_ready) k++;
            @(posedge clk); #1;
        end
        check("rst_mid_progress", 32'(k), 32'd4);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_in_ready", 32'(o_in_ready), 32'd0);
        run_packet(1'b0, 2'd0, 6'h2A, 16'd24, 1'b0, "after_rst");
        check("after_rst_footer", 32'(got_w[got_w.size() - 1]), 32'hE569);

        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                dt = 6'($urandom_range(16, 63));
                wc = 16'(2 * $urandom_range(0, 20));
            end else begin
                dt = 6'($urandom_range(0, 15));
                wc = 16'($urandom);
            end
            load_random((dt >= 6'h10) ? int'(wc) / 2 : 0);
            run_packet(1'b0, 2'($urandom), dt, wc, 1'b1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
